// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue between a request/acknowledge instruction memory and IF/ID.
// Holds up to DEPTH {instr, pc+4} entries; a taken branch flushes it and discards in-flight fetches.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic                     imem_ack_i,
  input  logic [31:0]              imem_data_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     instr_valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_plus4_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DISCARD
  } state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [31:0]        req_addr;
  logic [31:0]        req_addr_inc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               push;
  logic               pop;
  logic               room;
  entry_t             mem [DEPTH];

  // Queue occupancy after this cycle's push/pop; redirect suppresses both.
  assign req_addr_inc = req_addr + 32'd4;
  assign pop          = instr_valid_o & instr_ready_i & ~redirect_i;
  assign push         = (state == BUSY) & imem_ack_i & ~redirect_i;
  assign count_next   = count + CNT_W'(push) - CNT_W'(pop);
  assign room         = count_next < CNT_W'(DEPTH);

  // Head view is combinational from storage and occupancy.
  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? mem[rd_ptr].instr    : 32'd0;
  assign pc_plus4_o    = instr_valid_o ? mem[rd_ptr].pc_plus4 : 32'd0;
  assign count_o       = count;
  assign full_o        = (count == CNT_W'(DEPTH));
  assign empty_o       = (count == '0);
  assign imem_req_o    = (state != IDLE);
  assign imem_addr_o   = req_addr;

  // Entry storage: contents are only visible through count, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{instr: imem_data_i, pc_plus4: req_addr_inc};
    end
  end

  // Circular pointers and occupancy; a redirect flushes everything on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Fetch control: at most one request outstanding; DISCARD drains a request made stale by a branch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
          end else if (room) begin
            req_addr <= fetch_pc;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            state    <= imem_ack_i ? IDLE : DISCARD;
          end else if (imem_ack_i) begin
            fetch_pc <= req_addr_inc;
            if (room) begin
              req_addr <= req_addr_inc;
            end else begin
              state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (redirect_i) fetch_pc <= redirect_pc_i;
          if (imem_ack_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus randomized streams
// checked against an in-order instruction-stream model.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              imem_req_o;
  logic [31:0]       imem_addr_o;
  logic              imem_ack_i;
  logic [31:0]       imem_data_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic              instr_valid_o;
  logic [31:0]       instr_o;
  logic [31:0]       pc_plus4_o;
  logic              instr_ready_i;
  logic [CNT_W-1:0]  count_o;
  logic              full_o;
  logic              empty_o;

  int checks   = 0;
  int failures = 0;

  // Memory model: word returned equals its address, ws_cur wait states per request.
  int ws_cur    = 0;
  int ws_max    = 0;
  bit ws_rand   = 1'b0;
  int wait_cnt  = 0;
  int ack_total = 0;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Advance one clock, then drive this cycle's memory response from the current request.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (imem_req_o) begin
      if (wait_cnt >= ws_cur) begin
        imem_ack_i  = 1'b1;
        imem_data_i = imem_addr_o;
        wait_cnt    = 0;
        ack_total++;
        if (ws_rand) ws_cur = $urandom_range(0, ws_max);
      end else begin
        imem_ack_i  = 1'b0;
        imem_data_i = 32'hDEAD_BEEF;
        wait_cnt++;
      end
    end else begin
      imem_ack_i  = 1'b0;
      imem_data_i = 32'hDEAD_BEEF;
      wait_cnt    = 0;
    end
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    ws_rand = 1'b0; ws_cur = 0;
    do_reset();
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", imem_addr_o); end
    checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", instr_valid_o); end
    checks++; if (instr_o !== 32'd0 || pc_plus4_o !== 32'd0) begin failures++; $display("FAIL reset_head got=%0h/%0h exp=0/0", instr_o, pc_plus4_o); end
    checks++; if (int'(count_o) != 0 || empty_o !== 1'b1 || full_o !== 1'b0) begin failures++; $display("FAIL reset_flags got=cnt%0d e%0b f%0b exp=cnt0 e1 f0", count_o, empty_o, full_o); end
  endtask

  task automatic test_stream();
    ws_rand = 1'b0; ws_cur = 0;
    do_reset();
    instr_ready_i = 1'b1;
    next_cycle();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd0 || instr_valid_o !== 1'b0) begin
      failures++; $display("FAIL stream_first_req got=req%0b addr%0h v%0b exp=req1 addr0 v0", imem_req_o, imem_addr_o, instr_valid_o);
    end
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'(4 * k) || pc_plus4_o !== 32'(4 * k + 4)) begin
        failures++; $display("FAIL stream_word%0d got=v%0b %0h/%0h exp=v1 %0h/%0h", k, instr_valid_o, instr_o, pc_plus4_o, 4 * k, 4 * k + 4);
      end
    end
    instr_ready_i = 1'b0;
  endtask

  task automatic test_full();
    int acks0;
    ws_rand = 1'b0; ws_cur = 0;
    do_reset();
    acks0 = ack_total;
    repeat (10) next_cycle();
    checks++; if (ack_total - acks0 != 4) begin failures++; $display("FAIL full_push_count got=%0d exp=4", ack_total - acks0); end
    checks++; if (int'(count_o) != 4 || full_o !== 1'b1 || empty_o !== 1'b0 || imem_req_o !== 1'b0) begin
      failures++; $display("FAIL full_state got=cnt%0d f%0b e%0b req%0b exp=cnt4 f1 e0 req0", count_o, full_o, empty_o, imem_req_o);
    end
    checks++; if (instr_o !== 32'd0 || pc_plus4_o !== 32'd4) begin failures++; $display("FAIL full_head got=%0h/%0h exp=0/4", instr_o, pc_plus4_o); end
    instr_ready_i = 1'b1;
    next_cycle();
    instr_ready_i = 1'b0;
    checks++; if (int'(count_o) != 3 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || instr_o !== 32'h4) begin
      failures++; $display("FAIL full_refetch got=cnt%0d req%0b addr%0h head%0h exp=cnt3 req1 addr10 head4", count_o, imem_req_o, imem_addr_o, instr_o);
    end
    repeat (5) next_cycle();
    checks++; if (ack_total - acks0 != 5 || int'(count_o) != 4 || imem_req_o !== 1'b0) begin
      failures++; $display("FAIL full_one_refetch got=acks%0d cnt%0d req%0b exp=acks5 cnt4 req0", ack_total - acks0, count_o, imem_req_o);
    end
  endtask

  task automatic test_redirect_wait();
    bit found;
    ws_rand = 1'b0; ws_cur = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      next_cycle();
      if (imem_req_o && imem_addr_o == 32'h8) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rw_wait_req8 got=timeout exp=request to 8"); end
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    next_cycle();
    redirect_i = 1'b0;
    checks++; if (int'(count_o) != 0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
      failures++; $display("FAIL rw_discard_hold got=cnt%0d req%0b addr%0h exp=cnt0 req1 addr8", count_o, imem_req_o, imem_addr_o);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      next_cycle();
      if (!(imem_req_o && imem_addr_o == 32'h8)) found = 1'b1;
    end
    checks++; if (!found || int'(count_o) != 0) begin failures++; $display("FAIL rw_stale_dropped got=done%0b cnt%0d exp=done1 cnt0", found, count_o); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req_o) found = 1'b1; else next_cycle();
    end
    checks++; if (!found || imem_addr_o !== 32'h40) begin failures++; $display("FAIL rw_target_req got=req%0b addr%0h exp=req1 addr40", found, imem_addr_o); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      next_cycle();
      if (instr_valid_o) found = 1'b1;
    end
    checks++; if (!found || instr_o !== 32'h40 || pc_plus4_o !== 32'h44 || int'(count_o) != 1) begin
      failures++; $display("FAIL rw_target_head got=v%0b %0h/%0h cnt%0d exp=v1 40/44 cnt1", found, instr_o, pc_plus4_o, count_o);
    end
  endtask

  task automatic test_redirect_ack_pop();
    bit found;
    ws_rand = 1'b0; ws_cur = 0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      next_cycle();
      if (int'(count_o) == 2 && imem_ack_i) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rap_setup got=timeout exp=count2 with ack"); end
    instr_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    next_cycle();
    instr_ready_i = 1'b0; redirect_i = 1'b0;
    checks++; if (int'(count_o) != 0 || instr_valid_o !== 1'b0 || empty_o !== 1'b1 || instr_o !== 32'd0 || imem_req_o !== 1'b0) begin
      failures++; $display("FAIL rap_flush got=cnt%0d v%0b e%0b i%0h req%0b exp=cnt0 v0 e1 i0 req0", count_o, instr_valid_o, empty_o, instr_o, imem_req_o);
    end
    next_cycle();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin failures++; $display("FAIL rap_target_req got=req%0b addr%0h exp=req1 addr100", imem_req_o, imem_addr_o); end
    next_cycle();
    checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h100 || pc_plus4_o !== 32'h104 || int'(count_o) != 1) begin
      failures++; $display("FAIL rap_target_head got=v%0b %0h/%0h cnt%0d exp=v1 100/104 cnt1", instr_valid_o, instr_o, pc_plus4_o, count_o);
    end
  endtask

  task automatic test_reset_busy();
    bit found;
    ws_rand = 1'b0; ws_cur = 0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      next_cycle();
      if (int'(count_o) == 3 && imem_req_o) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rb_setup got=timeout exp=busy with 3 queued"); end
    rst_i = 1'b1;
    next_cycle();
    checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'd0 || instr_valid_o !== 1'b0 || instr_o !== 32'd0 || pc_plus4_o !== 32'd0) begin
      failures++; $display("FAIL rb_outputs got=req%0b addr%0h v%0b %0h/%0h exp=all zero", imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_plus4_o);
    end
    checks++; if (int'(count_o) != 0 || empty_o !== 1'b1 || full_o !== 1'b0) begin failures++; $display("FAIL rb_flags got=cnt%0d e%0b f%0b exp=cnt0 e1 f0", count_o, empty_o, full_o); end
    rst_i = 1'b0;
    next_cycle();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd0) begin failures++; $display("FAIL rb_restart got=req%0b addr%0h exp=req1 addr0", imem_req_o, imem_addr_o); end
  endtask

  // Random ready/wait states/redirects; the model is an in-order address stream plus a stale-fetch flag.
  task automatic test_random(input int redirect_pct, input int pops_goal, input int max_wait);
    logic [31:0] exp_pc;
    int          model_cnt;
    int          pops;
    bit          stale;
    bit          pending;
    logic [31:0] pending_addr;
    bit          pop;
    ws_rand = 1'b1; ws_max = max_wait; ws_cur = 0;
    do_reset();
    exp_pc = 32'd0; model_cnt = 0; pops = 0; stale = 1'b0; pending = 1'b0; pending_addr = 32'd0;
    for (int cyc = 0; cyc < 4000 && pops < pops_goal; cyc++) begin
      next_cycle();
      checks++; if (int'(count_o) != model_cnt || instr_valid_o !== (model_cnt != 0) ||
                    full_o !== (model_cnt == int'(DEPTH)) || empty_o !== (model_cnt == 0)) begin
        failures++; $display("FAIL rnd_count cyc%0d got=cnt%0d v%0b f%0b e%0b exp=cnt%0d", cyc, count_o, instr_valid_o, full_o, empty_o, model_cnt);
      end
      if (pending) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== pending_addr) begin
          failures++; $display("FAIL rnd_req_hold cyc%0d got=req%0b addr%0h exp=req1 addr%0h", cyc, imem_req_o, imem_addr_o, pending_addr);
        end
      end
      pending      = imem_req_o && !imem_ack_i;
      pending_addr = imem_addr_o;
      instr_ready_i = ($urandom_range(0, 2) != 0);
      redirect_i    = (int'($urandom_range(0, 99)) < redirect_pct);
      redirect_pc_i = $urandom & 32'h0000_FFFC;
      pop = (model_cnt > 0) && instr_ready_i && !redirect_i;
      if (pop) begin
        checks++; if (instr_o !== exp_pc || pc_plus4_o !== exp_pc + 32'd4) begin
          failures++; $display("FAIL rnd_order pop%0d got=%0h/%0h exp=%0h/%0h", pops, instr_o, pc_plus4_o, exp_pc, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redirect_i) begin
        model_cnt = 0;
        exp_pc    = redirect_pc_i;
      end else begin
        model_cnt = model_cnt - int'(pop) + int'(imem_ack_i && !stale);
      end
      if (imem_ack_i) stale = 1'b0;
      else if (redirect_i && imem_req_o) stale = 1'b1;
    end
    redirect_i = 1'b0; instr_ready_i = 1'b0;
    checks++; if (pops < pops_goal) begin failures++; $display("FAIL rnd_progress got=%0d exp=%0d pops", pops, pops_goal); end
  endtask

  initial begin
    rst_i = 1'b1; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    imem_ack_i = 1'b0; imem_data_i = 32'hDEAD_BEEF;
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_reset_busy();
    test_random(0, 40, 2);
    test_random(8, 60, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
